mac_fifo_ctrl: RTL and testbench
================================

Name: mac_fifo_ctrl

Overview:
- Sequencer that sits directly upstream of the 8x8 multiply-accumulate unit.
- Pops operand pairs from two show-ahead FIFOs (A and B) and drives the MAC's Ain/Bin/En/Clr.
- Runs one dot product of VEC_LEN pairs per start command, then captures the 24-bit MAC result.
- Presents the result on a valid/ready output port.

Parameters:
- VEC_LEN, 8: number of operand pairs per dot product. Legal range 1..258, so that 255*255*VEC_LEN fits in ACC_W. Elaboration-time assertion on out-of-range values.
- DATA_W, 8: operand width. Must match the MAC Ain/Bin width.
- ACC_W, 24: accumulator/result width. Must match the MAC Cout width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one dot product; sampled only in IDLE, or in RESULT on the handshake cycle
- a_empty  in  1  FIFO A empty flag
- a_q  in  DATA_W  FIFO A head word; valid whenever a_empty=0 (show-ahead)
- a_rden  out  1  pop FIFO A
- b_empty  in  1  FIFO B empty flag
- b_q  in  DATA_W  FIFO B head word; show-ahead
- b_rden  out  1  pop FIFO B
- mac_En  out  1  MAC accumulate enable
- mac_Clr  out  1  MAC synchronous clear
- mac_Ain  out  DATA_W  MAC operand A
- mac_Bin  out  DATA_W  MAC operand B
- mac_Cout  in  ACC_W  MAC registered result
- busy  out  1  high in every state except IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  ACC_W  captured dot-product result

Behaviour:
- Reset (async, rst_n=0): state goes to IDLE; count=0; res_data=0; res_valid=0. All combinational outputs evaluate to 0 in IDLE.
- Reset mid-operation: abandons the vector; pairs already popped are lost. The MAC shares rst_n, so it is also cleared. The next start begins clean.
- FSM states and transitions:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: one cycle, mac_Clr=1 -> FEED, with count=0.
  - FEED: pair_ok = !a_empty && !b_empty. When pair_ok=1:
    - a_rden = b_rden = mac_En = 1
    - mac_Ain = a_q, mac_Bin = b_q (combinational, same cycle)
    - count increments
    - When pair_ok=1 and count==VEC_LEN-1 -> DRAIN.
    - When pair_ok=0: stall. No pop on either FIFO (never pop only one side), mac_En=0, mac_Ain/mac_Bin=0.
  - DRAIN: one cycle. mac_Cout now holds the final sum; res_data <= mac_Cout; res_valid <= 1 -> RESULT.
  - RESULT: res_valid=1 and res_data held stable until res_ready=1.
    - On the handshake, res_valid <= 0.
    - If start=1 on the handshake cycle -> CLEAR directly (back-to-back operation); otherwise -> IDLE.
- mac_Clr is asserted only in CLEAR; mac_En only in FEED with pair_ok; the two are never asserted together.
- start outside IDLE is ignored, except in RESULT on the handshake cycle.
- Latency with no stalls: start sampled at edge E0 -> res_valid high after edge E0+VEC_LEN+2 (one CLEAR cycle, VEC_LEN FEED cycles, one DRAIN cycle). Each stall cycle adds one.
- Arithmetic is done inside the MAC: unsigned, with no overflow for a legal VEC_LEN. This block performs no arithmetic beyond the counter.
- Counter width is $clog2(VEC_LEN+1).

Decomposition:
- Shared package mac_pkg:
  - DATA_W, ACC_W constants
  - state enum {IDLE, CLEAR, FEED, DRAIN, RESULT}
  - MAX_VEC_LEN = 258
- No sub-module needed: single FSM plus counter plus result register, about 150 lines.
- The bench instantiates mac_fifo_ctrl, the MAC, and two show-ahead FIFO models.

Test Plan:
- VEC_LEN=4, A={1,2,3,4}, B={5,6,7,8} preloaded, res_ready=1, start pulse -> res_data=70 (0x000046), res_valid exactly 6 cycles after start; exactly 4 pops per FIFO.
- VEC_LEN=4, all operands 255 -> res_data=260100 (0x03F804); no wrap.
- Same vectors as the first case, but b_empty forced high for 3 cycles after the 2nd pair -> no pops and mac_En=0 during the stall; res_data=70; latency 9 cycles.
- res_ready low for 5 cycles after res_valid rises -> res_data and res_valid stable for all 5 cycles; handshake with start=1 -> mac_Clr the next cycle; second vector {1,1,1,1}x{2,2,2,2} gives 8.
- rst_n pulsed low mid-FEED after 2 pairs -> all outputs 0 immediately; then new start with fresh vectors {1,2,3,4}x{1,1,1,1} -> res_data=10.
- start pulsed while busy (FEED and DRAIN) -> ignored; exactly one result is produced.

Source files
------------

// File: rtl/mac_fifo_ctrl_pkg.sv
// Shared constants and FSM state type for the MAC operand sequencer.
package mac_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ACC_W       = 24;
    localparam int unsigned MAX_VEC_LEN = 258;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        RESULT
    } state_e;

endpackage

// File: rtl/mac_fifo_ctrl_if.sv
// FIFO, MAC and result-port bundle; master is the sequencer, slave its environment.
interface mac_fifo_ctrl_if #(
    parameter int unsigned DATA_W = mac_pkg::DATA_W,
    parameter int unsigned ACC_W  = mac_pkg::ACC_W
);
    logic              start;
    logic              a_empty;
    logic [DATA_W-1:0] a_q;
    logic              a_rden;
    logic              b_empty;
    logic [DATA_W-1:0] b_q;
    logic              b_rden;
    logic              mac_En;
    logic              mac_Clr;
    logic [DATA_W-1:0] mac_Ain;
    logic [DATA_W-1:0] mac_Bin;
    logic [ACC_W-1:0]  mac_Cout;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;

    modport master (
        input  start, a_empty, a_q, b_empty, b_q, mac_Cout, res_ready,
        output a_rden, b_rden, mac_En, mac_Clr, mac_Ain, mac_Bin,
               busy, res_valid, res_data
    );

    modport slave (
        output start, a_empty, a_q, b_empty, b_q, mac_Cout, res_ready,
        input  a_rden, b_rden, mac_En, mac_Clr, mac_Ain, mac_Bin,
               busy, res_valid, res_data
    );

endinterface

// File: rtl/mac_fifo_ctrl.sv
// Pops paired operands from two show-ahead FIFOs into the MAC, one dot
// product of VEC_LEN pairs per start, and returns the sum on a valid/ready port.
module mac_fifo_ctrl #(
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned DATA_W  = mac_pkg::DATA_W,
    parameter int unsigned ACC_W   = mac_pkg::ACC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_fifo_ctrl_if.master bus
);
    import mac_pkg::*;

    localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    if (VEC_LEN == 0 || VEC_LEN > MAX_VEC_LEN) begin : g_vec_len_check
        $error("mac_fifo_ctrl: VEC_LEN %0d outside 1..%0d", VEC_LEN, MAX_VEC_LEN);
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               valid_q, valid_d;
    logic               pair_ok;

    assign pair_ok = !bus.a_empty && !bus.b_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        valid_d     = valid_q;
        bus.a_rden  = 1'b0;
        bus.b_rden  = 1'b0;
        bus.mac_En  = 1'b0;
        bus.mac_Clr = 1'b0;
        bus.mac_Ain = '0;
        bus.mac_Bin = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                bus.mac_Clr = 1'b1;
                cnt_d       = '0;
                state_d     = FEED;
            end
            FEED: begin
                // Both sides pop together or not at all, so pairs never skew.
                if (pair_ok) begin
                    bus.a_rden  = 1'b1;
                    bus.b_rden  = 1'b1;
                    bus.mac_En  = 1'b1;
                    bus.mac_Ain = bus.a_q;
                    bus.mac_Bin = bus.b_q;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Cout is registered: the last product lands one cycle after its En.
                res_d   = bus.mac_Cout;
                valid_d = 1'b1;
                state_d = RESULT;
            end
            RESULT: begin
                if (bus.res_ready) begin
                    valid_d = 1'b0;
                    state_d = bus.start ? CLEAR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = valid_q;
    assign bus.res_data  = res_q;

endmodule

// File: tb/tb_mac_fifo_ctrl.sv
// Bench for mac_fifo_ctrl: FIFO and MAC models, scoreboard of dot products.
module tb_mac_fifo_ctrl;

    localparam int unsigned VL = 4;
    localparam int unsigned DW = mac_pkg::DATA_W;
    localparam int unsigned AW = mac_pkg::ACC_W;

    typedef int unsigned vec_t [VL];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_fifo_ctrl_if #(.DATA_W(DW), .ACC_W(AW)) dif ();

    mac_fifo_ctrl #(.VEC_LEN(VL), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    int checks   = 0;
    int failures = 0;

    // FIFO storage: stimulus writes at *_wr, FIFO model reads at *_rd
    logic [DW-1:0] fa [256];
    logic [DW-1:0] fb [256];
    int unsigned a_wr = 0, b_wr = 0, a_rd = 0, b_rd = 0;
    int unsigned a_pops = 0, b_pops = 0;

    // scoreboard of expected results
    logic [AW-1:0] exp_mem [64];
    int unsigned exp_wr = 0, exp_rd = 0, hs_cnt = 0;

    bit          rnd_gate   = 1'b0;
    bit          stall_mode = 1'b0;
    int unsigned stall_base = 0;
    int unsigned stall_left = 0;
    bit          hold_pend  = 1'b0;
    logic [AW-1:0] held     = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction

    // MAC model: registered, unsigned accumulate, shares rst_n
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           dif.mac_Cout <= '0;
        else if (dif.mac_Clr) dif.mac_Cout <= '0;
        else if (dif.mac_En)  dif.mac_Cout <= dif.mac_Cout + AW'(dif.mac_Ain) * AW'(dif.mac_Bin);
    end

    // FIFO model + monitor; reads pre-edge values
    always @(posedge clk) begin
        if (!rst_n) begin
            a_rd = a_wr;
            b_rd = b_wr;
            exp_rd = exp_wr;
            stall_left = 0;
            hold_pend = 1'b0;
        end else begin
            chk("rden_pair", 32'(dif.a_rden), 32'(dif.b_rden));
            chk("en_eq_pop", 32'(dif.mac_En), 32'(dif.a_rden));
            chk("clr_en_excl", 32'(dif.mac_Clr & dif.mac_En), 0);
            if (dif.a_rden) chk("pop_nonempty", 32'({dif.a_empty, dif.b_empty}), 0);
            if (!dif.mac_En) chk("idle_operands", 32'({dif.mac_Ain, dif.mac_Bin}), 0);
            else chk("operands", 32'({dif.mac_Ain, dif.mac_Bin}), 32'({fa[a_rd % 256], fb[b_rd % 256]}));

            if (hold_pend) begin
                chk("hold_valid", 32'(dif.res_valid), 1);
                chk("hold_data", 32'(dif.res_data), 32'(held));
            end
            hold_pend = dif.res_valid && !dif.res_ready;
            held = dif.res_data;

            if (dif.res_valid && dif.res_ready) begin
                if (exp_rd == exp_wr) chk("spurious_result", 32'(exp_wr != exp_rd), 1);
                else begin
                    chk("res_data", 32'(dif.res_data), 32'(exp_mem[exp_rd % 64]));
                    exp_rd++;
                end
                hs_cnt++;
            end

            if (dif.a_rden) begin a_rd++; a_pops++; end
            if (dif.b_rden) begin b_rd++; b_pops++; end
            if (stall_left > 0) stall_left--;
            if (stall_mode && dif.b_rden && (b_pops - stall_base) == 2) stall_left = 3;
        end
        dif.a_empty <= (a_rd == a_wr) || (rnd_gate && $urandom_range(0, 3) == 0);
        dif.b_empty <= (b_rd == b_wr) || (stall_left > 0) || (rnd_gate && $urandom_range(0, 3) == 0);
        dif.a_q     <= fa[a_rd % 256];
        dif.b_q     <= fb[b_rd % 256];
    end

    // reference: dot product with plain integer arithmetic
    task automatic push_vec(input vec_t a, input vec_t b);
        int unsigned s = 0;
        for (int unsigned i = 0; i < VL; i++) begin
            fa[a_wr % 256] = DW'(a[i]); a_wr++;
            fb[b_wr % 256] = DW'(b[i]); b_wr++;
            s += a[i] * b[i];
        end
        exp_mem[exp_wr % 64] = AW'(s);
        exp_wr++;
    endtask

    task automatic measure(output int unsigned lat);
        @(negedge clk); dif.start = 1'b1;
        @(posedge clk); lat = 0;
        @(negedge clk); dif.start = 1'b0;
        while (lat < 100) begin
            @(posedge clk); lat++;
            #1;
            if (dif.res_valid) break;
        end
    endtask

    task automatic wait_idle(input bit rnd, input int unsigned budget);
        int unsigned n = 0;
        @(negedge clk);
        while (dif.busy && n < budget) begin
            if (rnd) dif.res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(dif.busy), 0);
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_busy"}, 32'(dif.busy), 0);
        chk({tag, "_valid"}, 32'(dif.res_valid), 0);
        chk({tag, "_data"}, 32'(dif.res_data), 0);
        chk({tag, "_ctl"}, 32'({dif.a_rden, dif.b_rden, dif.mac_En, dif.mac_Clr}), 0);
        chk({tag, "_ops"}, 32'({dif.mac_Ain, dif.mac_Bin}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, vb, vc, vd, v1, v255;
        int unsigned lat, base_a, base_b, base_hs, n;
        va = '{1, 2, 3, 4};
        vb = '{5, 6, 7, 8};
        v1 = '{1, 1, 1, 1};
        vc = '{2, 2, 2, 2};
        v255 = '{255, 255, 255, 255};

        dif.start = 1'b0;
        dif.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero_outputs("idle");

        // basic dot product: 70, latency 6, 4 pops per side
        push_vec(va, vb);
        @(negedge clk);
        base_a = a_pops; base_b = b_pops;
        measure(lat);
        chk("lat_basic", lat, 6);
        wait_idle(1'b0, 50);
        chk("pops_a", a_pops - base_a, VL);
        chk("pops_b", b_pops - base_b, VL);

        // full-scale operands: 260100, no wrap
        push_vec(v255, v255);
        measure(lat);
        chk("lat_max", lat, 6);
        wait_idle(1'b0, 50);

        // B empty for 3 cycles after the 2nd pair
        push_vec(va, vb);
        @(negedge clk);
        stall_base = b_pops;
        stall_mode = 1'b1;
        measure(lat);
        chk("lat_stall", lat, 9);
        wait_idle(1'b0, 50);
        stall_mode = 1'b0;

        // consumer holds off 5 cycles, then back-to-back start on handshake
        dif.res_ready = 1'b0;
        push_vec(va, vb);
        measure(lat);
        chk("lat_hold", lat, 6);
        repeat (5) begin
            @(posedge clk); #1;
            chk("stable_valid", 32'(dif.res_valid), 1);
            chk("stable_data", 32'(dif.res_data), 70);
        end
        push_vec(v1, vc);
        @(negedge clk);
        dif.res_ready = 1'b1;
        dif.start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_clr", 32'(dif.mac_Clr), 1);
        @(negedge clk);
        dif.start = 1'b0;
        wait_idle(1'b0, 50);

        // reset mid-FEED after two pairs, then a fresh vector
        push_vec(va, vb);
        base_a = a_pops;
        @(negedge clk); dif.start = 1'b1;
        @(negedge clk); dif.start = 1'b0;
        n = 0;
        while (a_pops - base_a != 2 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("two_pairs_seen", a_pops - base_a, 2);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_vec(va, v1);
        measure(lat);
        chk("lat_after_reset", lat, 6);
        wait_idle(1'b0, 50);

        // start while busy in FEED and DRAIN is ignored
        push_vec(va, vb);
        base_hs = hs_cnt;
        @(negedge clk); dif.start = 1'b1;
        @(posedge clk);
        @(negedge clk); dif.start = 1'b0;
        @(negedge clk); dif.start = 1'b1;
        @(negedge clk); dif.start = 1'b0;
        repeat (3) @(negedge clk);
        dif.start = 1'b1;
        @(negedge clk); dif.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("one_result", hs_cnt - base_hs, 1);
        chk("busy_after_ignored", 32'(dif.busy), 0);

        // randomized vectors, FIFO gaps and consumer back-pressure
        rnd_gate = 1'b1;
        for (int unsigned t = 0; t < 20; t++) begin
            for (int unsigned i = 0; i < VL; i++) begin
                vd[i] = $urandom_range(0, 255);
                va[i] = $urandom_range(0, 255);
            end
            push_vec(va, vd);
            wait_idle(1'b1, 300);
            dif.start = 1'b1;
            @(negedge clk);
            dif.start = 1'b0;
        end
        wait_idle(1'b1, 600);
        rnd_gate = 1'b0;
        dif.res_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("all_results_drained", exp_rd, exp_wr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
